// File: rtl/ysyx_23060136_bpu_bht.sv
// Branch history table for the BPU.
// Direct-mapped table of {valid, tag, saturating counter, target}. It is looked up
// combinationally at fetch and updated when EXU2 resolves a B-type branch.
//
// Ports:
//   clk, rst            - clock (rising edge) and asynchronous active-low reset
//   IFU_pc              - lookup PC
//   BHT_hit             - lookup entry is valid and its tag matches
//   BHT_take            - predicted taken (hit and counter MSB set)
//   BHT_target          - predicted target, 0 on a miss
//   BHT_pc              - PC of the resolved branch
//   BHT_pre_true        - resolved, and the prediction was correct
//   BHT_pre_false       - resolved, and the prediction was wrong
//   BHT_pre_take        - the prediction that travelled with the branch
//   branch_target       - resolved branch target
//   BHT_flush           - invalidate the whole table (fence.i)
//   BHT_miss_cnt        - saturating count of mispredicts
module ysyx_23060136_bpu_bht #(
    parameter int unsigned BITS_W  = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned TAG_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BITS_W-1:0] IFU_pc,
    output logic              BHT_hit,
    output logic              BHT_take,
    output logic [BITS_W-1:0] BHT_target,
    input  logic [BITS_W-1:0] BHT_pc,
    input  logic              BHT_pre_true,
    input  logic              BHT_pre_false,
    input  logic              BHT_pre_take,
    input  logic [BITS_W-1:0] branch_target,
    input  logic              BHT_flush,
    output logic [31:0]       BHT_miss_cnt
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_LO = IDX_W + 2;
    localparam int unsigned TAG_HI = IDX_W + TAG_W + 1;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntWt  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CntWnt = CntWt - CNT_W'(1);

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [CNT_W-1:0]  cnt_q    [ENTRIES];
    logic [BITS_W-1:0] target_q [ENTRIES];
    logic [31:0]       miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0]  l_idx, u_idx;
    logic [TAG_W-1:0]  l_tag, u_tag;
    logic              u_hit, upd, outcome, wr_hit, wr_alloc;
    logic [CNT_W-1:0]  cnt_cur, cnt_nxt;

    // PC bits that neither index nor tag the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{IFU_pc[BITS_W-1:TAG_HI+1], IFU_pc[1:0],
                              BHT_pc[BITS_W-1:TAG_HI+1], BHT_pc[1:0]};

    // Lookup: purely combinational, sees registered state only (no update bypass).
    always_comb begin
        l_idx      = IFU_pc[TAG_LO-1:2];
        l_tag      = IFU_pc[TAG_HI:TAG_LO];
        BHT_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
        BHT_take   = BHT_hit && cnt_q[l_idx][CNT_W-1];
        BHT_target = BHT_hit ? target_q[l_idx] : '0;
    end

    // Update decode. A mispredict flips the carried prediction to give the real
    // outcome; pre_false dominates when both strobes are set.
    always_comb begin
        u_idx    = BHT_pc[TAG_LO-1:2];
        u_tag    = BHT_pc[TAG_HI:TAG_LO];
        u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        upd      = BHT_pre_true || BHT_pre_false;
        outcome  = BHT_pre_take ^ BHT_pre_false;
        cnt_cur  = cnt_q[u_idx];
        cnt_nxt  = cnt_cur;
        if (outcome && (cnt_cur != CntMax)) begin
            cnt_nxt = cnt_cur + CNT_W'(1);
        end else if (!outcome && (cnt_cur != '0)) begin
            cnt_nxt = cnt_cur - CNT_W'(1);
        end
        wr_hit   = upd && u_hit;
        // Not-taken misses are never allocated.
        wr_alloc = upd && !u_hit && outcome;

        miss_cnt_d = miss_cnt_q;
        if (BHT_pre_false && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                cnt_q[i]    <= CntWnt;
                target_q[i] <= '0;
            end
            miss_cnt_q <= '0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
            if (BHT_flush) begin
                // Flush beats any concurrent update; tags and targets are kept.
                for (int i = 0; i < ENTRIES; i++) begin
                    valid_q[i] <= 1'b0;
                    cnt_q[i]   <= CntWnt;
                end
            end else if (wr_alloc) begin
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                cnt_q[u_idx]    <= CntWt;
                target_q[u_idx] <= branch_target;
            end else if (wr_hit) begin
                cnt_q[u_idx] <= cnt_nxt;
                if (outcome) begin
                    target_q[u_idx] <= branch_target;
                end
            end
        end
    end

    assign BHT_miss_cnt = miss_cnt_q;

endmodule
